// File: rtl/venc1_fwd_if.sv
// ---------------------------------------------------------------------------
// venc1_fwd_if : coded-symbol stream from the venc1_fwd encoder to the
//                symbol mapper / rate matcher.
//
//   out_vld   master->slave  coded symbol valid
//   out_rdy   slave->master  downstream accepts the symbol
//   out_bits  master->slave  {y2,y1,y0} for the current encoder step
//   out_last  master->slave  high with the final (tail) beat of a block
// ---------------------------------------------------------------------------
interface venc1_fwd_if;
    logic       out_vld;
    logic       out_rdy;
    logic [2:0] out_bits;
    logic       out_last;

    modport master (
        output out_vld,
        output out_bits,
        output out_last,
        input  out_rdy
    );

    modport slave (
        input  out_vld,
        input  out_bits,
        input  out_last,
        output out_rdy
    );
endinterface

// File: rtl/venc1_fwd.sv
// ---------------------------------------------------------------------------
// venc1_fwd : rate-1/3, constraint-length-9 convolutional encoder.
//
// A start pulse captures up to CB_MAX information bits. The block is then
// streamed as one 3-bit coded symbol per accepted beat, followed by TAIL_LEN
// zero tail bits that flush the shift register back to state 0 (the state the
// vdec1 traceback starts from). Bit 0 of info_bits is encoded first.
//
// Ports
//   clk           clock
//   rst           synchronous active-high reset; aborts a block in flight
//   start         one-cycle pulse, captures info_bits and codeblk_size
//   codeblk_size  info bits in the block, legal range 1..CB_MAX
//   info_bits     info_bits[k] is the k-th bit in time
//   start_err     one-cycle pulse after a start with an illegal size
//   busy          encoder active (start to the cycle after done)
//   done          one-cycle pulse after the final beat is accepted
//   out_if        coded symbol stream (valid/ready, master side)
// ---------------------------------------------------------------------------
module venc1_fwd #(
    parameter int         CB_MAX   = 29,
    parameter int         TAIL_LEN = 8,
    parameter logic [8:0] G0       = 9'o557,
    parameter logic [8:0] G1       = 9'o663,
    parameter logic [8:0] G2       = 9'o711
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [4:0]        codeblk_size,
    input  logic [CB_MAX-1:0] info_bits,
    output logic              start_err,
    output logic              busy,
    output logic              done,
    venc1_fwd_if.master       out_if
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_TAIL,
        S_DONE
    } state_t;

    state_t            state;
    logic [CB_MAX-1:0] info_q;
    logic [4:0]        size_q;
    logic [7:0]        sr;      // sr[7] = u(k-1) ... sr[0] = u(k-8)
    logic [5:0]        step;    // beat index of the symbol on out_bits (0..36)

    // Coded symbol for one 9-bit window w = {u, sr}.
    function automatic logic [2:0] encode(input logic [8:0] w);
        return {^(w & G2), ^(w & G1), ^(w & G0)};
    endfunction

    logic       accept;
    logic       size_ok;
    logic       u_cur;
    logic [7:0] sr_nxt;
    logic [5:0] step_nxt;
    logic       more_data;
    logic       u_nxt;
    logic [5:0] last_step;
    logic       at_last;
    logic [2:0] sym_start;
    logic [2:0] sym_nxt;

    assign accept    = out_if.out_vld && out_if.out_rdy;
    assign size_ok   = (codeblk_size != 5'd0) && (codeblk_size <= 5'(CB_MAX));

    // Input bit of the step currently on the output; tail steps feed zeros.
    assign u_cur     = (state == S_DATA) ? info_q[step[4:0]] : 1'b0;
    assign sr_nxt    = {u_cur, sr[7:1]};
    assign step_nxt  = step + 6'd1;

    // The symbol for step_nxt is precomputed so it can be registered and
    // presented the cycle after acceptance, keeping out_bits free of any
    // combinational path from out_rdy.
    assign more_data = step_nxt < {1'b0, size_q};
    assign u_nxt     = more_data ? info_q[step_nxt[4:0]] : 1'b0;
    assign sym_nxt   = encode({u_nxt, sr_nxt});

    // The first symbol sees an all-zero shift register.
    assign sym_start = encode({info_bits[0], 8'd0});

    assign last_step = {1'b0, size_q} + 6'(TAIL_LEN - 1);
    assign at_last   = (step == last_step);

    // NOTE: every register is written with <= so all of them update from the
    // values of the previous cycle, regardless of statement order below.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            info_q          <= '0;
            size_q          <= '0;
            sr              <= '0;
            step            <= '0;
            start_err       <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            out_if.out_vld  <= 1'b0;
            out_if.out_bits <= '0;
            out_if.out_last <= 1'b0;
        end else begin
            // Pulse outputs default low and are raised for one cycle below.
            start_err <= 1'b0;
            done      <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (size_ok) begin
                            info_q          <= info_bits;
                            size_q          <= codeblk_size;
                            sr              <= '0;
                            step            <= '0;
                            busy            <= 1'b1;
                            out_if.out_vld  <= 1'b1;
                            out_if.out_bits <= sym_start;
                            out_if.out_last <= 1'b0;
                            state           <= S_DATA;
                        end else begin
                            start_err <= 1'b1;
                        end
                    end
                end

                S_DATA, S_TAIL: begin
                    // Without acceptance nothing moves, so the presented
                    // symbol stays stable under backpressure.
                    if (accept) begin
                        sr <= sr_nxt;
                        if (at_last) begin
                            out_if.out_vld  <= 1'b0;
                            out_if.out_bits <= '0;
                            out_if.out_last <= 1'b0;
                            done            <= 1'b1;
                            state           <= S_DONE;
                        end else begin
                            step            <= step_nxt;
                            out_if.out_bits <= sym_nxt;
                            out_if.out_last <= (step_nxt == last_step);
                            if (!more_data) begin
                                state <= S_TAIL;
                            end
                        end
                    end
                end

                // busy covers the done cycle, so a start arriving alongside
                // done is ignored.
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_venc1_fwd.sv
// ---------------------------------------------------------------------------
// tb_venc1_fwd : self-checking bench for venc1_fwd.
//
// Expected symbols come from a time-domain convolution of the info bits with
// the generator taps and are queued when a block is started; a monitor pops
// and compares on every accepted beat, checks stability under backpressure,
// and runs an error-free inverse of the G0 branch to recover the info bits.
// ---------------------------------------------------------------------------
module tb_venc1_fwd;

    logic        clk;
    logic        rst;
    logic        start;
    logic [4:0]  codeblk_size;
    logic [28:0] info_bits;
    logic        start_err;
    logic        busy;
    logic        done;

    venc1_fwd_if out_if ();

    venc1_fwd dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .codeblk_size (codeblk_size),
        .info_bits    (info_bits),
        .start_err    (start_err),
        .busy         (busy),
        .done         (done),
        .out_if       (out_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [8:0] gens [3];
    logic [3:0] exp_q [$];      // {last, y2, y1, y0}

    int          cur_size;
    logic [28:0] cur_info;
    int          beat_cnt;
    int          last_block_beats;
    int          rdy_mode;      // 0: always ready, 1: 1,0,0 pattern, 2: random

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: y_i(k) = XOR over j of G_i[8-j] & u(k-j), with u zero outside
    // 0..size-1; the final tail step carries last.
    task automatic push_expected(input int size, input logic [28:0] info);
        for (int k = 0; k < size + 8; k++) begin
            logic [2:0] y;
            y = '0;
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 9; j++) begin
                    if (k - j >= 0 && k - j < size) begin
                        y[i] = y[i] ^ (gens[i][8-j] & info[k-j]);
                    end
                end
            end
            exp_q.push_back({(k == size + 7), y});
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Ready driver.
    initial begin
        int ph;
        ph = 0;
        out_if.out_rdy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_if.out_rdy = 1'b1;
                1:       out_if.out_rdy = (ph % 3 == 0);
                default: out_if.out_rdy = 1'($urandom_range(0, 1));
            endcase
            ph++;
        end
    end

    // Monitor: scoreboard compare, stall stability and loopback decode.
    initial begin
        logic [4:0]  prev_out;
        logic        prev_stall;
        logic [7:0]  hist;
        logic [28:0] dec;
        logic [28:0] mask;
        logic [3:0]  e;
        logic        u;
        prev_stall = 1'b0;
        prev_out   = '0;
        hist       = '0;
        dec        = '0;
        beat_cnt   = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                beat_cnt   = 0;
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_hold", {27'd0, out_if.out_vld, out_if.out_last, out_if.out_bits}, {27'd0, prev_out});
                end
                if (out_if.out_vld && out_if.out_rdy) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat", {28'd0, out_if.out_last, out_if.out_bits}, {28'd0, e});
                    end
                    if (beat_cnt == 0) begin
                        hist = '0;
                        dec  = '0;
                    end
                    if (beat_cnt < cur_size) begin
                        u = out_if.out_bits[0] ^ (^(gens[0][7:0] & hist));
                        dec[beat_cnt] = u;
                    end else begin
                        u = 1'b0;
                    end
                    hist = {u, hist[7:1]};
                    beat_cnt++;
                    if (out_if.out_last) begin
                        mask = '0;
                        for (int i = 0; i < cur_size; i++) mask[i] = 1'b1;
                        check("loopback", {3'd0, dec & mask}, {3'd0, cur_info & mask});
                        check("last_index", beat_cnt - 1, cur_size + 7);
                        last_block_beats = beat_cnt;
                        beat_cnt = 0;
                    end
                end
                prev_stall = out_if.out_vld && !out_if.out_rdy;
                prev_out   = {1'b1, out_if.out_last, out_if.out_bits};
            end
        end
    end

    // Drives one start pulse; returns the cycle in which start was presented.
    task automatic start_block(input int size, input logic [28:0] info, input bit accepted, output int t_start);
        @(posedge clk);
        #1;
        start        = 1'b1;
        codeblk_size = 5'(size);
        info_bits    = info;
        t_start      = cyc;
        if (accepted) begin
            cur_size = size;
            cur_info = info;
            push_expected(size, info);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Waits (bounded) for done; checks the completion sequence.
    task automatic wait_done(input int budget, output int t_done);
        bit found;
        found  = 1'b0;
        t_done = -1;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (done) begin
                found  = 1'b1;
                t_done = cyc;
            end
        end
        check("done_seen", 32'(found), 32'd1);
        if (found) begin
            check("done_vld_low", 32'(out_if.out_vld), 32'd0);
            check("done_busy_high", 32'(busy), 32'd1);
            check("queue_drained", exp_q.size(), 0);
            @(negedge clk);
            check("done_one_cycle", 32'(done), 32'd0);
            check("busy_after_done", 32'(busy), 32'd0);
        end
        exp_q.delete();
    endtask

    initial begin
        int ts;
        int td;
        int sz;
        gens[0] = 9'o557;
        gens[1] = 9'o663;
        gens[2] = 9'o711;
        rdy_mode = 0;
        cur_size = 0;
        cur_info = '0;
        last_block_beats = 0;
        rst = 1'b1;
        start = 1'b0;
        codeblk_size = '0;
        info_bits = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {26'd0, start_err, busy, done, out_if.out_vld, out_if.out_last, out_if.out_bits},
              32'd0);
        rst = 1'b0;

        // Impulse, always ready.
        start_block(1, 29'd1, 1'b1, ts);
        check("first_vld", 32'(out_if.out_vld), 32'd1);
        check("busy_after_start", 32'(busy), 32'd1);
        wait_done(100, td);
        check("impulse_done_cycle", td, ts + 10);
        check("impulse_beats", last_block_beats, 9);

        // All-zero maximal block.
        start_block(29, 29'd0, 1'b1, ts);
        check("zero_first_vld", 32'(out_if.out_vld), 32'd1);
        wait_done(100, td);
        check("zero_done_cycle", td, ts + 38);
        check("zero_beats", last_block_beats, 37);

        // Impulse under 1,0,0 backpressure.
        rdy_mode = 1;
        start_block(1, 29'd1, 1'b1, ts);
        wait_done(200, td);
        check("bp_beats", last_block_beats, 9);
        rdy_mode = 0;

        // Illegal sizes.
        start_block(0, 29'h155, 1'b0, ts);
        check("err_size0", {30'd0, start_err, busy}, {30'd0, 2'b10});
        @(posedge clk);
        #1;
        check("err_size0_pulse", {30'd0, start_err, busy}, 32'd0);
        start_block(31, 29'h1abc, 1'b0, ts);
        check("err_size31", {29'd0, start_err, busy, out_if.out_vld}, {29'd0, 3'b100});
        @(posedge clk);
        #1;
        check("err_size31_pulse", {30'd0, start_err, busy}, 32'd0);

        // Overlapping start is ignored.
        rdy_mode = 2;
        start_block(12, 29'h0a5c, 1'b1, ts);
        repeat (4) @(posedge clk);
        start_block(20, 29'h1f0f0f0f, 1'b0, ts);
        check("overlap_no_err", 32'(start_err), 32'd0);
        wait_done(300, td);
        check("overlap_beats", last_block_beats, 20);

        // Reset abort at beat 10 of a size-29 block.
        rdy_mode = 0;
        start_block(29, 29'($urandom), 1'b1, ts);
        begin
            bit hit;
            hit = 1'b0;
            for (int i = 0; i < 100 && !hit; i++) begin
                @(negedge clk);
                if (beat_cnt == 10) hit = 1'b1;
            end
            check("abort_reach_beat10", 32'(hit), 32'd1);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        check("abort_outputs", {26'd0, start_err, busy, done, out_if.out_vld, out_if.out_last, out_if.out_bits},
              32'd0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("abort_no_done", {30'd0, done, out_if.out_vld}, 32'd0);
        end
        start_block(1, 29'd1, 1'b1, ts);
        wait_done(100, td);
        check("post_abort_done_cycle", td, ts + 10);
        check("post_abort_beats", last_block_beats, 9);

        // Random blocks with random backpressure (loopback checked per block).
        rdy_mode = 2;
        for (int n = 0; n < 300; n++) begin
            sz = $urandom_range(1, 29);
            start_block(sz, 29'($urandom), 1'b1, ts);
            wait_done(400, td);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
